// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default limits
// and the rotating-priority pick used by the round-robin selector.
package uart_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_GRANT = 1'b1;

  localparam int DEFAULT_MAX_BURST    = 16;
  localparam int DEFAULT_IDLE_TIMEOUT = 1024;

  // Widest requester vector the picker handles; narrower users zero-extend.
  localparam int MAX_REQ = 8;
  localparam int PTR_W   = 3;

  // One-hot of the first set bit of req at or after ptr, scanning cyclically
  // over the lowest n positions. Returns zero when no bit is set.
  function automatic logic [MAX_REQ-1:0] rr_onehot(
    input logic [MAX_REQ-1:0] req,
    input logic [PTR_W-1:0]   ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] sel;
    logic               found;
    int                 idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (!found && req[idx[PTR_W-1:0]]) begin
          sel[idx[PTR_W-1:0]] = 1'b1;
          found               = 1'b1;
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side handshake bundle of the UART transmit arbiter.
// The arbiter takes the slave view; requesters, transmitter and benches take the master view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;

  logic                          tx_valid;
  logic                          tx_ready;
  logic [DATA_WIDTH-1:0]         tx_data;

  logic [NUM_REQ-1:0]            grant;
  logic                          busy;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant, busy
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
// Generic over the vector width so other shared resources can reuse it.
module rr_select
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] pick;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    pick  = rr_onehot(req_ext, PTR_W'(ptr), NUM_REQ);
    grant = pick[NUM_REQ-1:0];
    any   = |pick;
    idx   = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// A grant is held for a whole packet, bounded by MAX_BURST bytes and an idle timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = DEFAULT_MAX_BURST,
  parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
  input logic             pclk,
  input logic             prstn,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [IDLE_W-1:0]  IDLE_SAT   = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REQ - 1);

  state_t               state;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     rr_ptr;
  logic [BURST_W-1:0]   burst_cnt;
  logic [IDLE_W-1:0]    idle_cnt;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic                 active;
  logic                 own_valid;
  logic                 own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                 xfer;
  logic                 release_now;
  logic [IDX_W-1:0]     next_ptr;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) own_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Outputs are gated by prstn so a byte can never complete on the reset edge.
  assign active    = prstn && (state == ST_GRANT);
  assign own_valid = |(bus.req_valid & grant_q);
  assign own_last  = |(bus.req_last & grant_q);

  assign bus.tx_valid  = active && own_valid;
  assign bus.tx_data   = active ? own_data : '0;
  assign bus.req_ready = active ? (grant_q & {NUM_REQ{bus.tx_ready}}) : '0;
  assign bus.grant     = active ? grant_q : '0;
  assign bus.busy      = active;

  assign xfer        = bus.tx_valid && bus.tx_ready;
  assign release_now = active &&
                       ((xfer && (own_last || (burst_cnt == BURST_LAST))) ||
                        (!own_valid && (idle_cnt == IDLE_LAST)));
  assign next_ptr    = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge pclk) begin
    if (!prstn) begin
      state     <= ST_IDLE;
      grant_q   <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else if (state == ST_IDLE) begin
      if (pick_any) begin
        state   <= ST_GRANT;
        grant_q <= pick_grant;
        owner   <= pick_idx;
      end
    end else if (release_now) begin
      state     <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr    <= next_ptr;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      if (xfer) burst_cnt <= burst_cnt + BURST_W'(1);
      if (own_valid) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_SAT) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

  a_grant_onehot : assert property (@(posedge pclk) disable iff (!prstn)
    (state == ST_GRANT) |-> $onehot(grant_q));

  a_idle_no_grant : assert property (@(posedge pclk) disable iff (!prstn)
    (state == ST_IDLE) |-> (grant_q == '0));

  a_burst_bound : assert property (@(posedge pclk) disable iff (!prstn)
    burst_cnt < BURST_W'(MAX_BURST));

endmodule
